// File: rtl/fp_addsub_if.sv
// fp_addsub_if: operand/result valid-ready bundle for fp_addsub_pipe
interface fp_addsub_if #(parameter int EXP_W = 8, parameter int MAN_W = 23);
  localparam int W = 1 + EXP_W + MAN_W;
  logic in_vld, in_rdy, op, out_vld, out_rdy;
  logic [W-1:0] a, b, result;
  logic [3:0] flags;
  modport master (output in_vld, op, a, b, out_rdy, input in_rdy, out_vld, result, flags);
  modport slave (input in_vld, op, a, b, out_rdy, output in_rdy, out_vld, result, flags);
endinterface

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 6-stage parametrised FP add/sub, round-to-nearest-even, valid/ready stall.
// Flags {invalid, overflow, underflow, inexact} are only built when FP_ADDSUB_FLAGS_EN is defined.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic clk,
  input logic rst,
  fp_addsub_if.slave io
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int M = MAN_W + 4;
  localparam int E2 = EXP_W + 2;
  localparam int LZ_W = $clog2(M + 1);
  localparam logic signed [E2-1:0] ONE = E2'(1);
  localparam logic signed [E2-1:0] EMAX = E2'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  logic en;
  logic [5:0] v;
  logic [5:1] sx_p, spc_p, zs_p;
  logic [2:1] sub_p;
  logic [EXP_W-1:0] ex_p [1:4];
  logic [W-1:0] sres_p [1:5];
  logic [EXP_W-1:0] ea, eb, ed, d1;
  logic [MAN_W-1:0] fa, fb;
  logic sa, sb, za, zb, ia, ib, na, nb, swap, iminf;
  logic sx0, spc0, zs0;
  logic [W-1:0] sres0;
  logic [M-1:0] mx0, my0, mx1, my1, mx2, my2, y2;
  logic [M:0] sum3, sum4;
  logic [LZ_W-1:0] lz, lz4;
  logic signed [E2-1:0] e5n, e5, e6;
  logic [M-1:0] m5n, m5;
  logic [MAN_W+1:0] mr;
  logic g6, rs6, ovf, unf, zero6;
  logic [W-1:0] res6, result;
  assign en = !v[5] || io.out_rdy;
  assign io.in_rdy = en;
  assign io.out_vld = v[5];
  assign io.result = result;
  always_comb begin
    sa = io.a[W-1];
    sb = io.b[W-1] ^ io.op;
    ea = io.a[W-2:MAN_W];
    eb = io.b[W-2:MAN_W];
    za = ea == '0;
    zb = eb == '0;
    fa = za ? '0 : io.a[MAN_W-1:0];
    fb = zb ? '0 : io.b[MAN_W-1:0];
    ia = &ea && fa == '0;
    ib = &eb && fb == '0;
    na = &ea && fa != '0;
    nb = &eb && fb != '0;
    iminf = ia && ib && sa != sb;
    swap = {eb, fb} > {ea, fa};
    sx0 = swap ? sb : sa;
    ed = swap ? eb - ea : ea - eb;
    mx0 = swap ? {!zb, fb, 3'b000} : {!za, fa, 3'b000};
    my0 = swap ? {!za, fa, 3'b000} : {!zb, fb, 3'b000};
    spc0 = na || nb || ia || ib;
    sres0 = (na || nb || iminf) ? QNAN : {ia ? sa : sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    zs0 = za && zb && sa && sb;
  end
  // Far-shifted operand collapses to a lone sticky bit
  always_comb y2 = int'(d1) >= MAN_W + 3 ? M'(|my1) : (my1 >> d1) | M'(|(my1 & ~({M{1'b1}} << d1)));
  always_comb begin
    lz = LZ_W'(M);
    for (int i = 0; i < M; i++) if (sum3[i]) lz = LZ_W'(M - 1 - i);
  end
  always_comb begin
    e5n = sum4[M] ? $signed({2'b00, ex_p[4]}) + ONE : $signed({2'b00, ex_p[4]}) - $signed(E2'(lz4));
    m5n = sum4[M] ? {sum4[M:2], |sum4[1:0]} : sum4[M-1:0] << lz4;
  end
  always_comb begin
    g6 = m5[2];
    rs6 = |m5[1:0];
    mr = {1'b0, m5[M-1:3]} + (MAN_W+2)'(g6 && (rs6 || m5[3]));
    e6 = e5 + $signed(E2'(mr[MAN_W+1]));
    zero6 = m5 == '0;
    ovf = !e6[E2-1] && e6 >= EMAX;
    unf = e6[E2-1] || e6 == '0;
    res6 = spc_p[5] ? sres_p[5]
         : zero6 ? {zs_p[5], {(W-1){1'b0}}}
         : ovf ? {sx_p[5], {EXP_W{1'b1}}, {MAN_W{1'b0}}}
         : unf ? {sx_p[5], {(W-1){1'b0}}}
         : {sx_p[5], e6[EXP_W-1:0], mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      result <= '0;
    end else if (en) begin
      v <= {v[4:0], io.in_vld};
      result <= res6;
    end
    if (en) begin
      sx_p <= {sx_p[4:1], sx0};
      spc_p <= {spc_p[4:1], spc0};
      zs_p <= {zs_p[4:1], zs0};
      sub_p <= {sub_p[1], sa != sb};
      ex_p[1] <= swap ? eb : ea;
      sres_p[1] <= sres0;
      for (int k = 2; k <= 4; k++) ex_p[k] <= ex_p[k-1];
      for (int k = 2; k <= 5; k++) sres_p[k] <= sres_p[k-1];
      mx1 <= mx0;
      my1 <= my0;
      d1 <= ed;
      mx2 <= mx1;
      my2 <= y2;
      sum3 <= sub_p[2] ? {1'b0, mx2} - {1'b0, my2} : {1'b0, mx2} + {1'b0, my2};
      sum4 <= sum3;
      lz4 <= lz;
      m5 <= m5n;
      e5 <= e5n;
    end
  end
`ifdef FP_ADDSUB_FLAGS_EN
  logic inv0;
  logic [5:1] inv_p;
  logic [3:0] flags_q;
  always_comb inv0 = (na && !fa[MAN_W-1]) || (nb && !fb[MAN_W-1]) || iminf;
  always_ff @(posedge clk) begin
    if (rst) flags_q <= '0;
    else if (en) flags_q <= spc_p[5] ? {inv_p[5], 3'b000} : zero6 ? 4'b0000 : {1'b0, ovf, unf, ovf || unf || g6 || rs6};
    if (en) inv_p <= {inv_p[4:1], inv0};
  end
  assign io.flags = flags_q;
`else
  assign io.flags = 4'b0000;
`endif
endmodule
